// File: rtl/cs_pkg.sv
// Shared definitions for the compressed-sensing frame encoder: ternary codes,
// FSM state encoding and the per-code contribution helper.
package cs_pkg;

    localparam logic [1:0] CS_ZERO = 2'b00;
    localparam logic [1:0] CS_POS  = 2'b01;
    localparam logic [1:0] CS_NEG  = 2'b11;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } cs_state_e;

    // Returned at 32 bits; callers narrow to their accumulator width, which is
    // always wide enough to hold the product. The reserved code 2'b10 contributes 0.
    function automatic logic signed [31:0] cs_apply(input logic [1:0] code,
                                                    input logic signed [31:0] sample);
        case (code)
            CS_POS:  return sample;
            CS_NEG:  return -sample;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/cs_coef_mem.sv
// M x N ternary coefficient store: one full column is written per cycle and
// one full column is read combinationally; everything clears on reset.
module cs_coef_mem #(
    parameter int M = 48,
    parameter int N = 96
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic [$clog2(N)-1:0]         wr_col_i,
    input  logic [2*M-1:0]               wr_codes_i,
    input  logic [$clog2(N)-1:0]         rd_col_i,
    output logic [2*M-1:0]               rd_codes_o
);

    localparam int CW = $clog2(N);

    logic [2*M-1:0] mem_q [N];
    logic           wr_in_range;

    assign wr_in_range = ({1'b0, wr_col_i} < (CW+1)'(N));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < N; j++) begin
                mem_q[j] <= '0;
            end
        end else if (wr_en_i && wr_in_range) begin
            mem_q[wr_col_i] <= wr_codes_i;
        end
    end

    assign rd_codes_o = mem_q[rd_col_i];

endmodule

// File: rtl/cs_frame_encoder.sv
// Streaming y = Phi*x encoder with a run-time programmable ternary matrix.
// Define CS_SAT_EN to clamp measurements to OUT_W instead of wrapping.
module cs_frame_encoder
    import cs_pkg::*;
#(
    parameter int M      = 48,
    parameter int N      = 96,
    parameter int DATA_W = 4,
    parameter int OUT_W  = 8
) (
    input  logic                     sys_clk,
    input  logic                     sys_reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     cfg_we,
    input  logic [$clog2(N)-1:0]     cfg_col,
    input  logic [2*M-1:0]           cfg_codes,
    output logic                     cfg_ok,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(N+1)-1:0]   col_count,
    output logic                     sat_flag,
    output logic                     dbg_state
);

    localparam int ACC_W = DATA_W + $clog2(N) + 1;
    localparam int CW    = $clog2(N);
    localparam int CCW   = $clog2(N+1);
    localparam int IW    = (M > 1) ? $clog2(M) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid and its payload stay stable until that edge.

    cs_state_e                 state_q;
    logic signed [ACC_W-1:0]   acc_q [M];
    logic signed [ACC_W-1:0]   acc_d [M];
    logic [CCW-1:0]            col_count_q;
    logic [IW-1:0]             out_idx_q;
    logic [IW-1:0]             next_idx;
    logic                      out_valid_q;
    logic                      out_last_q;
    logic [OUT_W-1:0]          out_data_q;
    logic                      sat_q;
    logic [2*M-1:0]            cur_codes;
    logic signed [31:0]        samp_ext;
    logic                      accept;

    function automatic logic [OUT_W:0] cs_convert(input logic signed [ACC_W-1:0] a);
`ifdef CS_SAT_EN
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = ACC_W'((1 <<< (OUT_W-1)) - 1);
        min_v = ACC_W'(-(1 <<< (OUT_W-1)));
        if (a > max_v) begin
            return {1'b1, max_v[OUT_W-1:0]};
        end else if (a < min_v) begin
            return {1'b1, min_v[OUT_W-1:0]};
        end
        return {1'b0, a[OUT_W-1:0]};
`else
        return {1'b0, a[OUT_W-1:0]};
`endif
    endfunction

    assign in_ready = (state_q == ACCUM);
    assign accept   = in_valid && in_ready;
    assign cfg_ok   = cfg_we && (state_q == ACCUM) && (col_count_q == '0);
    assign next_idx = out_idx_q + 1'b1;

    // The column read is combinational from the stored codes, so a write landing
    // on the same edge as the column-0 accept only affects the next frame.
    cs_coef_mem #(
        .M(M),
        .N(N)
    ) u_coef_mem (
        .clk_i      (sys_clk),
        .rst_i      (sys_reset),
        .wr_en_i    (cfg_ok),
        .wr_col_i   (cfg_col),
        .wr_codes_i (cfg_codes),
        .rd_col_i   (col_count_q[CW-1:0]),
        .rd_codes_o (cur_codes)
    );

    always_comb begin
        samp_ext = 32'(signed'(in_data));
        for (int i = 0; i < M; i++) begin
            acc_d[i] = acc_q[i] + ACC_W'(cs_apply(cur_codes[2*i +: 2], samp_ext));
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q     <= ACCUM;
            for (int i = 0; i < M; i++) begin
                acc_q[i] <= '0;
            end
            col_count_q <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_q       <= acc_d;
                        col_count_q <= col_count_q + 1'b1;
                        // Row 0 is presented straight from the updated sums so the
                        // first measurement appears one cycle after the last sample.
                        if (col_count_q == CCW'(N-1)) begin
                            state_q               <= DRAIN;
                            out_valid_q           <= 1'b1;
                            {sat_q, out_data_q}   <= cs_convert(acc_d[0]);
                            out_last_q            <= (M == 1);
                            out_idx_q             <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= ACCUM;
                            for (int i = 0; i < M; i++) begin
                                acc_q[i] <= '0;
                            end
                            col_count_q <= '0;
                            out_idx_q   <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            sat_q       <= 1'b0;
                        end else begin
                            out_idx_q             <= next_idx;
                            {sat_q, out_data_q}   <= cs_convert(acc_q[next_idx]);
                            out_last_q            <= (next_idx == IW'(M-1));
                        end
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;
    assign col_count = col_count_q;
    assign dbg_state = state_q;

endmodule

// File: doc/cs_frame_encoder.md
Name: cs_frame_encoder

Overview:
- Parametrised successor to the fixed 48x96 compressed-sensing encoder.
- Computes y = Phi*x for one frame of N signed input samples, using an M x N ternary measurement matrix (-1/0/+1).
- The matrix is run-time programmable, column-wise, instead of hard-coded.
- Sits between the sample source and the measurement transmitter: streaming valid/ready in, M measurements out per frame.

Parameters:
- M, 48, measurement rows (number of accumulators / output words per frame)
- N, 96, samples per frame (matrix columns)
- DATA_W, 4, signed input sample width
- OUT_W, 8, signed output word width
- ACC_W (localparam), DATA_W+$clog2(N)+1, internal accumulator width (12 at defaults)

Ports:
- sys_clk  in  1  clock
- sys_reset  in  1  synchronous active-high reset
- in_data  in  DATA_W  signed sample x[col]
- in_valid  in  1  sample valid
- in_ready  out  1  block accepts a sample this cycle
- cfg_we  in  1  write one matrix column
- cfg_col  in  $clog2(N)  column index to write
- cfg_codes  in  2*M  codes for rows 0..M-1 (row i at bits [2i+1:2i])
- cfg_ok  out  1  a cfg write this cycle takes effect
- out_data  out  OUT_W  signed measurement y[out_idx]
- out_valid  out  1  measurement valid
- out_ready  in  1  downstream accepts
- out_last  out  1  marks row M-1
- col_count  out  $clog2(N+1)  samples accepted in current frame
- sat_flag  out  1  current out_data was clamped (0 without CS_SAT_EN)

Behaviour:
- Code encoding: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1, 2'b10 = reserved, treated as 0.
- Reset (sys_reset sampled high at clock edge):
  - state = ACCUM; all accumulators and all matrix codes = 0.
  - col_count = 0, out_idx = 0.
  - out_valid = 0, out_last = 0, out_data = 0, sat_flag = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-frame or mid-drain discards everything; no partial output is emitted.
- State ACCUM:
  - in_ready = 1.
  - Accept when in_valid & in_ready. On accept, in one cycle, for all rows i in parallel: acc[i] += code(i,col_count) * sext(in_data), in ACC_W (cannot overflow).
  - col_count increments on each accept.
  - The accept with col_count == N-1 moves to DRAIN next cycle; col_count shows N during DRAIN.
- State DRAIN:
  - in_ready = 0.
  - out_valid = 1; out_data = convert(acc[out_idx]); out_last = (out_idx == M-1).
  - Output is registered: it updates the cycle after a handshake. Hold stable while out_ready = 0.
  - On out_valid & out_ready: out_idx++.
  - On the handshake with out_last = 1: clear all acc, col_count = 0, out_idx = 0, out_valid = 0, return to ACCUM.
  - Latency: last sample accept to first out_valid = 1 cycle. Frame period at full throughput = N+M cycles.
- convert() without the macro: two's-complement truncation to the low OUT_W bits (wrap).
- Config writes:
  - Honoured only when state == ACCUM and col_count == 0; cfg_ok is combinational on that condition and cfg_we. Otherwise the write is silently dropped.
  - If cfg_we and a sample accept coincide at col_count 0, the sample uses the old column-0 codes; the new codes apply from the next frame.
  - cfg_col >= N is ignored.

Optional Feature:
- CS_SAT_EN defined:
  - convert() clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat_flag = 1 alongside any clamped out_data.
- CS_SAT_EN undefined: wrap truncation as above; sat_flag tied 0.
- No other behaviour differs.

Decomposition:
- Package cs_pkg:
  - code constants CS_ZERO, CS_POS, CS_NEG
  - state enum (ACCUM, DRAIN)
  - function cs_apply(code, sample) returning signed ACC_W contribution
- One natural sub-module: cs_coef_mem. M x N x 2-bit register array, column write port, column read port returning 2*M bits, synchronous clear on reset.

Test Plan:
1. Reset, program col 0 rows 0/1 = +1/-1, all else 0; send x0 = 3 then 95 zeros -> y[0] = 3, y[1] = -3, y[2..47] = 0; out_last only on the 48th word.
2. Diagonal-ish matrix, row i = +1 at col i for i < 48; x[j] = j mod 8 (signed 4-bit) -> y[i] = i mod 8; second identical frame gives identical output (accumulators cleared).
3. Row 0 = +1 on all 96 cols, x = 7 every sample -> acc = 672. Without CS_SAT_EN: out_data = 672 mod 256 = 8'hA0. With CS_SAT_EN: 127 with sat_flag = 1. Repeat with x = -8 -> -768 wraps to 0, or clamps to -128.
4. Backpressure: out_ready toggled 1/0 in DRAIN -> each word held stable while low, exactly 48 handshakes, in_ready = 0 throughout DRAIN, no sample lost (in_valid held high).
5. cfg_we at col_count = 5 -> cfg_ok = 0, frame result unchanged. cfg_we coincident with the first accept -> that frame uses old codes, the next frame uses new codes.
6. Assert sys_reset at col_count = 40 and again at out_idx = 10 -> no further out_valid, col_count = 0, matrix all-zero (next frame outputs all 0).
